regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single register-file write port between three sources:
//   1. pipeline writeback (highest priority, never stalled),
//   2. a one-entry trap holding register that stores the return address into
//      $k0 (TRAP_REG) after an interrupt or undefined-instruction exception,
//   3. a two-entry FIFO of received UART bytes, each written zero-extended
//      into UART_REG0 or UART_REG1 according to its flag.
// The write port outputs are combinational from the current inputs and the
// internal state. Trap and UART requests are captured at the clock edge, so
// they can be written no earlier than the following cycle.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wb_regwrite           writeback write request
//   wb_write_register     writeback destination (register 0 = no write)
//   wb_write_data         writeback data
//   trap_req              one-cycle trap pulse
//   trap_is_exception     1 = exception (store PC+4), 0 = interrupt (store PC)
//   trap_pc_plus4         PC+4 of the trapped instruction
//   uart_signal           one-cycle pulse, new received byte
//   uart_flag             destination select for the byte
//   uart_rx_data          received byte
//   rf_we/rf_waddr/rf_wdata  register file write port
//   trap_ack              trap write issued this cycle
//   trap_pending          trap captured, not yet written
//   uart_count            UART FIFO occupancy (0..2)
//   uart_overflow         sticky, a UART byte was dropped
//   trap_overrun          sticky, a trap request was dropped
module regfile_write_arbiter #(
  parameter logic [4:0] UART_REG0 = 5'd24,
  parameter logic [4:0] UART_REG1 = 5'd25,
  parameter logic [4:0] TRAP_REG  = 5'd26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_write_register,
  input  logic [31:0] wb_write_data,
  input  logic        trap_req,
  input  logic        trap_is_exception,
  input  logic [31:0] trap_pc_plus4,
  input  logic        uart_signal,
  input  logic        uart_flag,
  input  logic [7:0]  uart_rx_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        trap_ack,
  output logic        trap_pending,
  output logic [1:0]  uart_count,
  output logic        uart_overflow,
  output logic        trap_overrun
);

  logic        r_trap_pending;
  logic [31:0] r_trap_data;
  logic [8:0]  r_ent0;           // FIFO head {flag, byte}
  logic [8:0]  r_ent1;           // FIFO second entry
  logic [1:0]  r_count;
  logic        r_uart_ovf;
  logic        r_trap_ovr;

  logic        w_wb_grant;
  logic        w_trap_grant;
  logic        w_uart_grant;
  logic [8:0]  w_ent0_n;
  logic [8:0]  w_ent1_n;
  logic [1:0]  w_count_n;
  logic        w_ovf_set;

  // Register 0 is hard-wired, so a writeback to it does not occupy the port.
  assign w_wb_grant   = wb_regwrite && (wb_write_register != 5'd0);
  assign w_trap_grant = !w_wb_grant && r_trap_pending;
  assign w_uart_grant = !w_wb_grant && !r_trap_pending && (r_count != 2'd0);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (w_wb_grant) begin
      rf_we    = 1'b1;
      rf_waddr = wb_write_register;
      rf_wdata = wb_write_data;
    end else if (w_trap_grant) begin
      rf_we    = 1'b1;
      rf_waddr = TRAP_REG;
      rf_wdata = r_trap_data;
    end else if (w_uart_grant) begin
      rf_we    = 1'b1;
      rf_waddr = r_ent0[8] ? UART_REG1 : UART_REG0;
      rf_wdata = {24'd0, r_ent0[7:0]};
    end
  end

  // FIFO next state: pop first, then the push lands in the first free slot,
  // so a push into a full FIFO that is popping in the same cycle is accepted.
  always_comb begin
    w_ent0_n  = r_ent0;
    w_ent1_n  = r_ent1;
    w_count_n = r_count;
    w_ovf_set = 1'b0;
    if (w_uart_grant) begin
      w_ent0_n  = r_ent1;
      w_count_n = r_count - 2'd1;
    end
    if (uart_signal) begin
      if (w_count_n == 2'd0) begin
        w_ent0_n  = {uart_flag, uart_rx_data};
        w_count_n = 2'd1;
      end else if (w_count_n == 2'd1) begin
        w_ent1_n  = {uart_flag, uart_rx_data};
        w_count_n = 2'd2;
      end else begin
        w_ovf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0     <= 9'd0;
      r_ent1     <= 9'd0;
      r_count    <= 2'd0;
      r_uart_ovf <= 1'b0;
    end else begin
      r_ent0     <= w_ent0_n;
      r_ent1     <= w_ent1_n;
      r_count    <= w_count_n;
      r_uart_ovf <= r_uart_ovf | w_ovf_set;
    end
  end

  // The holding register frees up in the cycle it is granted, so a new trap
  // arriving in that same cycle replaces it instead of being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap_pending <= 1'b0;
      r_trap_data    <= 32'd0;
      r_trap_ovr     <= 1'b0;
    end else if (trap_req) begin
      if (!r_trap_pending || w_trap_grant) begin
        r_trap_pending <= 1'b1;
        r_trap_data    <= trap_is_exception ? trap_pc_plus4
                                            : trap_pc_plus4 - 32'd4;
      end else begin
        r_trap_ovr <= 1'b1;
      end
    end else if (w_trap_grant) begin
      r_trap_pending <= 1'b0;
    end
  end

  assign trap_ack      = w_trap_grant;
  assign trap_pending  = r_trap_pending;
  assign uart_count    = r_count;
  assign uart_overflow = r_uart_ovf;
  assign trap_overrun  = r_trap_ovr;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_regwrite;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data;
  logic        trap_req;
  logic        trap_is_exception;
  logic [31:0] trap_pc_plus4;
  logic        uart_signal;
  logic        uart_flag;
  logic [7:0]  uart_rx_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        trap_ack;
  logic        trap_pending;
  logic [1:0]  uart_count;
  logic        uart_overflow;
  logic        trap_overrun;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wb_regwrite(wb_regwrite), .wb_write_register(wb_write_register),
    .wb_write_data(wb_write_data),
    .trap_req(trap_req), .trap_is_exception(trap_is_exception),
    .trap_pc_plus4(trap_pc_plus4),
    .uart_signal(uart_signal), .uart_flag(uart_flag), .uart_rx_data(uart_rx_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .trap_ack(trap_ack), .trap_pending(trap_pending), .uart_count(uart_count),
    .uart_overflow(uart_overflow), .trap_overrun(trap_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO as a queue of {flag, byte}, trap as a flag + value.
  logic [8:0]  m_q[$];
  bit          m_tp;
  logic [31:0] m_td;
  bit          m_ovf;
  bit          m_tovr;

  // DUT values observed in the last step, for hand-computed expectations.
  logic        o_we, o_ack, o_tp, o_ovf, o_tovr;
  logic [4:0]  o_addr;
  logic [31:0] o_data;
  logic [1:0]  o_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_tp = 0; m_td = 0; m_ovf = 0; m_tovr = 0;
  endtask

  task automatic set_in(input bit wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                        input bit tr, input bit te, input logic [31:0] tpc,
                        input bit us, input bit uf, input logic [7:0] ud);
    wb_regwrite = wbw; wb_write_register = wbr; wb_write_data = wbd;
    trap_req = tr; trap_is_exception = te; trap_pc_plus4 = tpc;
    uart_signal = us; uart_flag = uf; uart_rx_data = ud;
  endtask

  task automatic idle();
    set_in(0, 5'd0, 32'd0, 0, 0, 32'd0, 0, 0, 8'd0);
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic step();
    bit          wbg, tg, ug;
    bit          e_we, e_ack;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    if (!rst_n) model_clear();
    #1;
    wbg = wb_regwrite && (wb_write_register != 0);
    tg  = !wbg && m_tp;
    ug  = !wbg && !m_tp && (m_q.size() > 0);
    e_we = wbg || tg || ug;
    e_ack = tg;
    e_addr = 0; e_data = 0;
    if (wbg) begin e_addr = wb_write_register; e_data = wb_write_data; end
    else if (tg) begin e_addr = 5'd26; e_data = m_td; end
    else if (ug) begin e_addr = m_q[0][8] ? 5'd25 : 5'd24; e_data = {24'd0, m_q[0][7:0]}; end
    chk("rf_we", rf_we, e_we);
    chk("rf_waddr", rf_waddr, e_addr);
    chk("rf_wdata", rf_wdata, e_data);
    chk("trap_ack", trap_ack, e_ack);
    chk("trap_pending", trap_pending, m_tp);
    chk("uart_count", uart_count, m_q.size());
    chk("uart_overflow", uart_overflow, m_ovf);
    chk("trap_overrun", trap_overrun, m_tovr);
    o_we = rf_we; o_addr = rf_waddr; o_data = rf_wdata; o_ack = trap_ack;
    o_tp = trap_pending; o_cnt = uart_count; o_ovf = uart_overflow; o_tovr = trap_overrun;
    @(posedge clk);
    if (rst_n) begin
      if (trap_req) begin
        if (!m_tp || tg) begin
          m_tp = 1;
          m_td = trap_is_exception ? trap_pc_plus4 : trap_pc_plus4 - 32'd4;
        end else m_tovr = 1;
      end else if (tg) m_tp = 0;
      if (ug) void'(m_q.pop_front());
      if (uart_signal) begin
        if (m_q.size() < 2) m_q.push_back({uart_flag, uart_rx_data});
        else m_ovf = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; idle();
    repeat (2) step();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; idle(); model_clear();
    @(negedge clk);
    step();
    chk("reset_we", o_we, 0);
    chk("reset_count", o_cnt, 0);
    chk("reset_tp", o_tp, 0);
    chk("reset_ack", o_ack, 0);
    rst_n = 1;

    // WB wins over a pending UART byte, which follows the next cycle.
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 8'hAB); step();
    set_in(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0); step();
    chk("d1_wb_addr", o_addr, 5); chk("d1_wb_data", o_data, 32'h1234);
    idle(); step();
    chk("d1_u_we", o_we, 1); chk("d1_u_addr", o_addr, 24); chk("d1_u_data", o_data, 32'hAB);

    // Interrupt stores PC+4-4 into $k0 one cycle after the pulse.
    set_in(0, 0, 0, 1, 0, 32'h00400010, 0, 0, 0); step();
    chk("d2_nowrite", o_we, 0);
    idle(); step();
    chk("d2_addr", o_addr, 26); chk("d2_data", o_data, 32'h0040000C); chk("d2_ack", o_ack, 1);
    step();
    chk("d2_tp_clr", o_tp, 0);

    // Exception held behind WB; a second trap during the hold is dropped.
    set_in(1, 5'd3, 32'h33, 1, 1, 32'h0, 0, 0, 0); step();
    set_in(1, 5'd3, 32'h34, 0, 0, 0, 0, 0, 0); step();
    chk("d3_held", o_tp, 1);
    set_in(1, 5'd3, 32'h35, 1, 1, 32'h100, 0, 0, 0); step();
    idle(); step();
    chk("d3_addr", o_addr, 26); chk("d3_data", o_data, 32'h0); chk("d3_ovr", o_tovr, 1);

    // Three bytes while WB is busy: the third overflows.
    set_in(1, 5'd7, 32'h7, 0, 0, 0, 1, 0, 8'h11); step();
    set_in(1, 5'd7, 32'h7, 0, 0, 0, 1, 1, 8'h22); step();
    set_in(1, 5'd7, 32'h7, 0, 0, 0, 1, 0, 8'h33); step();
    set_in(1, 5'd7, 32'h7, 0, 0, 0, 0, 0, 0); step();
    chk("d4_count", o_cnt, 2); chk("d4_ovf", o_ovf, 1);
    idle(); step();
    chk("d4_w1_addr", o_addr, 24); chk("d4_w1_data", o_data, 32'h11);
    step();
    chk("d4_w2_addr", o_addr, 25); chk("d4_w2_data", o_data, 32'h22);
    step();
    chk("d4_empty", o_we, 0);

    // WB to register 0 leaves the port to the UART head.
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 8'h7F); step();
    set_in(1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0, 0); step();
    chk("d5_we", o_we, 1); chk("d5_addr", o_addr, 25); chk("d5_data", o_data, 32'h7F);

    // Reset discards a pending trap and a full FIFO.
    set_in(1, 5'd9, 32'h9, 1, 0, 32'h40, 1, 0, 8'h01); step();
    set_in(1, 5'd9, 32'h9, 0, 0, 0, 1, 0, 8'h02); step();
    rst_n = 0; set_in(1, 5'd4, 32'h44, 0, 0, 0, 0, 0, 0); step();
    chk("d6_tp", o_tp, 0); chk("d6_cnt", o_cnt, 0);
    chk("d6_rst_wb_we", o_we, 1); chk("d6_rst_wb_addr", o_addr, 4);
    idle(); step();
    rst_n = 1; step();
    chk("d6_no_write", o_we, 0);
    step();
    chk("d6_no_write2", o_we, 0);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(99) < 45, 5'($urandom_range(31) < 4 ? 0 : $urandom_range(31)),
             $urandom, $urandom_range(99) < 15, 1'($urandom), $urandom,
             $urandom_range(99) < 40, 1'($urandom), 8'($urandom));
      rst_n = ($urandom_range(199) != 0);
      step();
    end
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
